fifo_gen_flow: RTL and testbench
================================

# fifo_gen_flow

Parametrised successor to the team's basic valid/ready FIFO. Stores up to DEPTH words of WIDTH bits, and DEPTH need not be a power of two. Adds an occupancy count, programmable almost-full and almost-empty flags, a synchronous flush, and an optional fall-through mode. Sits between a producer and a consumer on any valid/ready stream in the design.

## Interface
- WIDTH, 4: data word width in bits, ≥1.
- DEPTH, 4: number of storage slots, ≥2, any integer.
- AF_THRESH, DEPTH-1: almost_full asserts when count ≥ AF_THRESH; legal range 1..DEPTH.
- AE_THRESH, 1: almost_empty asserts when count ≤ AE_THRESH; legal range 0..DEPTH-1.
- FALLTHRU, 0: 1 = an empty FIFO forwards in_data to out_data combinationally.
- Derived CW = $clog2(DEPTH+1): count width. Derived PW = $clog2(DEPTH): pointer width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous clear of all contents.
- in_val  in  1  producer data valid.
- in_rdy  out  1  FIFO can accept data.
- in_data  in  WIDTH  push data.
- out_val  out  1  head data valid.
- out_rdy  in  1  consumer accepts head.
- out_data  out  WIDTH  head data; usable in the same cycle as out_val.
- count  out  CW  stored words, 0..DEPTH.
- almost_full  out  1  count ≥ AF_THRESH.
- almost_empty  out  1  count ≤ AE_THRESH.

## Operation
- A push occurs when in_val && in_rdy. A pop occurs when out_val && out_rdy.
- **in_rdy:** in_rdy = !full, where full means count == DEPTH. A pop in the same cycle does not open a slot while full.
- **out_val:**
  - FALLTHRU=0: out_val = (count != 0).
  - FALLTHRU=1: out_val = (count != 0) || (count == 0 && in_val && !flush).
- **Write:** a push writes in_data to mem[wr_ptr]. wr_ptr then advances modulo DEPTH: at DEPTH-1 it goes to 0, with no power-of-two overflow assumed.
- **Read:** out_data = mem[rd_ptr] when count != 0. A pop advances rd_ptr modulo DEPTH.
- **Fall-through (FALLTHRU=1, count==0, in_val):** out_data = in_data.
  - With out_rdy=1, both push and pop occur. Nothing is written, neither pointer moves, count stays 0.
  - With out_rdy=0, the word is written normally.
- **Simultaneous push and pop (count in 1..DEPTH-1):** both pointers advance and count is unchanged.
- **count:** next count = count + push − pop, where a fall-through push+pop counts as 0. count never exceeds DEPTH and never goes below 0.
- **almost_full, almost_empty:** combinational compares on the registered count.
- **flush:** has priority over everything.
  - While flush=1: in_rdy is unaffected, but any push is discarded; out_val=0; pop is impossible.
  - Next cycle: count=0, wr_ptr=rd_ptr=0.
- Storage is not reset. out_data is don't-care while out_val=0.

## Timing
- Reset (async assert, released synchronously upstream) gives: count=0, pointers=0, in_rdy=1, out_val=0 (FALLTHRU=0, or in_val=0), almost_empty=1, almost_full=0.
- Reset asserted mid-operation discards all contents immediately.
- Latency, FALLTHRU=0: a word pushed in cycle N is visible on out_val/out_data in cycle N+1.
- Latency, FALLTHRU=1 and empty: the word is visible in cycle N, i.e. 0 cycles.
- count and both flags reflect the cycle-N handshakes in cycle N+1.
- in_rdy depends only on registered state. It has no combinational path from out_rdy or in_val.
- out_val has a combinational path from in_val only when FALLTHRU=1.

## Structure
- Shared package fifo_gen_pkg holds:
  - function ptr_inc(ptr, depth): modular increment.
  - CW/PW derivation helpers.
- Sub-module fifo_ptr_mod holds one PW-bit pointer with enable, synchronous clear (flush) and wrap at DEPTH-1. It is instantiated twice, for write and read.
- The top level holds storage, count, flags and fall-through muxing.
- Target size is roughly 180–250 lines of RTL in total.

## Test plan
All scenarios use DEPTH=5, WIDTH=8, AF_THRESH=4, AE_THRESH=1, FALLTHRU=0 unless stated otherwise.
- **Fill, wrap and drain:** push 0x11..0x15 with out_rdy=0 → count 1..5, almost_full in the cycle after count reaches 4, in_rdy=0 at count=5. Then pop 5 times → 0x11..0x15 in order, almost_empty at count ≤1, rd_ptr wraps 4→0.
- **Sustained simultaneous traffic:** with count=2, run push+pop every cycle for 12 cycles → count stays 2, output order equals input order, pointers wrap at 5 twice.
- **Full with pop:** at count=5, drive in_val=1 and out_rdy=1 → only the pop occurs, in_rdy stays 0 that cycle, count goes 4 next cycle, the next push is accepted.
- **Flush:** at count=3 assert flush together with in_val=1 → the push is discarded, count=0 next cycle, out_val=0. The next push of 0xAA is popped first.
- **Fall-through (FALLTHRU=1):**
  - Empty with in_data=0x5C, in_val=1, out_rdy=1 → out_val=1 and out_data=0x5C in the same cycle, count stays 0.
  - Repeat with out_rdy=0 → count=1 next cycle, then 0x5C is popped.
- **Reset mid-operation:** at count=4, pulse rst_n low between edges → outputs immediately go to the reset values listed under Timing, and the first push afterwards appears at out_data one cycle later.

Source files
------------

// File: rtl/fifo_gen_pkg.sv
// Shared helpers for the generic FIFO: width derivations, modular pointer increment
// and the per-cycle transfer decode.
package fifo_gen_pkg;

    function automatic int unsigned cw_of(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int unsigned pw_of(input int unsigned depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    // Wraps at depth-1 explicitly so non-power-of-two depths work.
    function automatic logic [31:0] ptr_inc(input logic [31:0] ptr, input int unsigned depth);
        return (ptr == 32'(depth - 1)) ? 32'd0 : ptr + 32'd1;
    endfunction

    typedef struct packed {
        logic push;
        logic pop;
        logic bypass;
    } xfer_t;

endpackage

// File: rtl/fifo_gen_flow_if.sv
// Valid/ready stream plus status bundle for fifo_gen_flow.
interface fifo_gen_flow_if
    import fifo_gen_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CW = cw_of(DEPTH);

    logic             flush;
    logic             in_val;
    logic             in_rdy;
    logic [WIDTH-1:0] in_data;
    logic             out_val;
    logic             out_rdy;
    logic [WIDTH-1:0] out_data;
    logic [CW-1:0]    count;
    logic             almost_full;
    logic             almost_empty;

    modport master (
        output flush, in_val, in_data, out_rdy,
        input  in_rdy, out_val, out_data, count, almost_full, almost_empty
    );

    modport slave (
        input  flush, in_val, in_data, out_rdy,
        output in_rdy, out_val, out_data, count, almost_full, almost_empty
    );
endinterface

// File: rtl/fifo_ptr_mod.sv
// Modulo-DEPTH pointer with enable and synchronous clear; clear wins over enable.
module fifo_ptr_mod
    import fifo_gen_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PW    = pw_of(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          en_i,
    output logic [PW-1:0] ptr_o
);
    logic [PW-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (en_i) begin
            ptr_d = PW'(ptr_inc(32'(ptr_q), DEPTH));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;
endmodule

// File: rtl/fifo_gen_flow.sv
// Parametrised valid/ready FIFO with occupancy count, almost-full/empty flags,
// synchronous flush and optional fall-through when empty.
module fifo_gen_flow
    import fifo_gen_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned AF_THRESH = DEPTH - 1,
    parameter int unsigned AE_THRESH = 1,
    parameter bit          FALLTHRU  = 1'b0
) (
    input logic            clk,
    input logic            rst_n,
    fifo_gen_flow_if.slave bus
);
    localparam int unsigned CW = cw_of(DEPTH);
    localparam int unsigned PW = pw_of(DEPTH);

    logic [CW-1:0]    count_q, count_d;
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             empty, full, ft_active, wr_en, rd_en;
    xfer_t            xfer;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));

    // Fall-through only while empty; flush suppresses it like any other output.
    assign ft_active = FALLTHRU && empty && bus.in_val && !bus.flush;

    assign bus.in_rdy  = !full;
    assign bus.out_val = !bus.flush && (!empty || ft_active);

    assign xfer.push   = bus.in_val && !full && !bus.flush;
    assign xfer.pop    = bus.out_val && bus.out_rdy;
    assign xfer.bypass = ft_active && bus.out_rdy;

    assign wr_en = xfer.push && !xfer.bypass;
    assign rd_en = xfer.pop && !xfer.bypass;

    assign bus.out_data = ft_active ? bus.in_data : mem_q[rd_ptr];

    always_comb begin
        count_d = count_q + CW'(wr_en) - CW'(rd_en);
        if (bus.flush) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr] <= bus.in_data;
        end
    end

    fifo_ptr_mod #(
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (bus.flush),
        .en_i  (wr_en),
        .ptr_o (wr_ptr)
    );

    fifo_ptr_mod #(
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (bus.flush),
        .en_i  (rd_en),
        .ptr_o (rd_ptr)
    );

    assign bus.count        = count_q;
    assign bus.almost_full  = (count_q >= CW'(AF_THRESH));
    assign bus.almost_empty = (count_q <= CW'(AE_THRESH));
endmodule

// File: tb/tb_fifo_gen_flow.sv
// Scoreboard bench: DUT a is registered-output (FALLTHRU=0), DUT b is fall-through.
module tb_fifo_gen_flow;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fifo_gen_flow_if #(.WIDTH(8), .DEPTH(5)) a_if ();
    fifo_gen_flow_if #(.WIDTH(8), .DEPTH(5)) b_if ();

    fifo_gen_flow #(
        .WIDTH(8), .DEPTH(5), .AF_THRESH(4), .AE_THRESH(1), .FALLTHRU(1'b0)
    ) u_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (a_if)
    );

    fifo_gen_flow #(
        .WIDTH(8), .DEPTH(5), .AF_THRESH(4), .AE_THRESH(1), .FALLTHRU(1'b1)
    ) u_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b_if)
    );

    int checks = 0;
    int errors = 0;
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    logic [7:0] exp_d;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv_a(input logic iv, input logic [7:0] d, input logic ordy, input logic fl);
        a_if.in_val = iv; a_if.in_data = d; a_if.out_rdy = ordy; a_if.flush = fl;
    endtask

    task automatic drv_b(input logic iv, input logic [7:0] d, input logic ordy, input logic fl);
        b_if.in_val = iv; b_if.in_data = d; b_if.out_rdy = ordy; b_if.flush = fl;
    endtask

    task automatic push_a(input logic [7:0] d);
        drv_a(1'b1, d, 1'b0, 1'b0);
        qa.push_back(d);
        tick();
    endtask

    task automatic test_reset();
        drv_a(1'b0, 8'h00, 1'b0, 1'b0);
        drv_b(1'b0, 8'h00, 1'b0, 1'b0);
        #2;
        checks++;
        if (a_if.count !== 3'd0 || a_if.in_rdy !== 1'b1 || a_if.out_val !== 1'b0) begin
            errors++;
            $display("FAIL reset_a count=%0d in_rdy=%b out_val=%b want 0 1 0",
                     a_if.count, a_if.in_rdy, a_if.out_val);
        end
        checks++;
        if (a_if.almost_empty !== 1'b1 || a_if.almost_full !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags ae=%b af=%b want 1 0", a_if.almost_empty, a_if.almost_full);
        end
        checks++;
        if (b_if.count !== 3'd0 || b_if.out_val !== 1'b0 || b_if.in_rdy !== 1'b1) begin
            errors++;
            $display("FAIL reset_b count=%0d out_val=%b in_rdy=%b want 0 0 1",
                     b_if.count, b_if.out_val, b_if.in_rdy);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 5; i++) begin
            drv_a(1'b1, 8'h11 + 8'(i), 1'b0, 1'b0);
            qa.push_back(8'h11 + 8'(i));
            @(negedge clk);
            checks++;
            if (a_if.count !== 3'(i) || a_if.in_rdy !== 1'b1) begin
                errors++;
                $display("FAIL fill_count[%0d] count=%0d in_rdy=%b want %0d 1",
                         i, a_if.count, a_if.in_rdy, i);
            end
            checks++;
            if (a_if.almost_full !== (i >= 4) || a_if.almost_empty !== (i <= 1)) begin
                errors++;
                $display("FAIL fill_flags[%0d] af=%b ae=%b want %b %b",
                         i, a_if.almost_full, a_if.almost_empty, i >= 4, i <= 1);
            end
            tick();
        end
        drv_a(1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (a_if.count !== 3'd5 || a_if.in_rdy !== 1'b0 || a_if.almost_full !== 1'b1) begin
            errors++;
            $display("FAIL full count=%0d in_rdy=%b af=%b want 5 0 1",
                     a_if.count, a_if.in_rdy, a_if.almost_full);
        end
        tick();
        for (int i = 0; i < 5; i++) begin
            drv_a(1'b0, 8'h00, 1'b1, 1'b0);
            @(negedge clk);
            exp_d = qa.pop_front();
            checks++;
            if (a_if.out_val !== 1'b1 || a_if.out_data !== exp_d) begin
                errors++;
                $display("FAIL drain_data[%0d] val=%b data=%h want 1 %h",
                         i, a_if.out_val, a_if.out_data, exp_d);
            end
            checks++;
            if (a_if.count !== 3'(5 - i) || a_if.almost_empty !== ((5 - i) <= 1)) begin
                errors++;
                $display("FAIL drain_count[%0d] count=%0d ae=%b want %0d %b",
                         i, a_if.count, a_if.almost_empty, 5 - i, (5 - i) <= 1);
            end
            tick();
        end
        drv_a(1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (a_if.count !== 3'd0 || a_if.out_val !== 1'b0 || a_if.almost_empty !== 1'b1) begin
            errors++;
            $display("FAIL drained count=%0d val=%b ae=%b want 0 0 1",
                     a_if.count, a_if.out_val, a_if.almost_empty);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        push_a(8'h20);
        push_a(8'h21);
        for (int i = 0; i < 12; i++) begin
            d = 8'h22 + 8'(i);
            drv_a(1'b1, d, 1'b1, 1'b0);
            @(negedge clk);
            exp_d = qa.pop_front();
            checks++;
            if (a_if.out_val !== 1'b1 || a_if.out_data !== exp_d) begin
                errors++;
                $display("FAIL b2b_data[%0d] val=%b data=%h want 1 %h",
                         i, a_if.out_val, a_if.out_data, exp_d);
            end
            checks++;
            if (a_if.count !== 3'd2 || a_if.in_rdy !== 1'b1) begin
                errors++;
                $display("FAIL b2b_count[%0d] count=%0d in_rdy=%b want 2 1",
                         i, a_if.count, a_if.in_rdy);
            end
            qa.push_back(d);
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            drv_a(1'b0, 8'h00, 1'b1, 1'b0);
            @(negedge clk);
            exp_d = qa.pop_front();
            checks++;
            if (a_if.out_data !== exp_d) begin
                errors++;
                $display("FAIL b2b_tail[%0d] data=%h want %h", i, a_if.out_data, exp_d);
            end
            tick();
        end
        drv_a(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_full_pop();
        for (int i = 0; i < 5; i++) push_a(8'h30 + 8'(i));
        drv_a(1'b1, 8'h99, 1'b1, 1'b0);
        @(negedge clk);
        exp_d = qa.pop_front();
        checks++;
        if (a_if.in_rdy !== 1'b0 || a_if.out_val !== 1'b1 || a_if.out_data !== exp_d) begin
            errors++;
            $display("FAIL fullpop in_rdy=%b val=%b data=%h want 0 1 %h",
                     a_if.in_rdy, a_if.out_val, a_if.out_data, exp_d);
        end
        tick();
        drv_a(1'b1, 8'h35, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (a_if.count !== 3'd4 || a_if.in_rdy !== 1'b1) begin
            errors++;
            $display("FAIL fullpop_after count=%0d in_rdy=%b want 4 1", a_if.count, a_if.in_rdy);
        end
        qa.push_back(8'h35);
        tick();
        for (int i = 0; i < 5; i++) begin
            drv_a(1'b0, 8'h00, 1'b1, 1'b0);
            @(negedge clk);
            exp_d = qa.pop_front();
            checks++;
            if (a_if.out_val !== 1'b1 || a_if.out_data !== exp_d) begin
                errors++;
                $display("FAIL fullpop_drain[%0d] val=%b data=%h want 1 %h",
                         i, a_if.out_val, a_if.out_data, exp_d);
            end
            tick();
        end
        drv_a(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) push_a(8'h40 + 8'(i));
        drv_a(1'b1, 8'h77, 1'b1, 1'b1);
        @(negedge clk);
        checks++;
        if (a_if.out_val !== 1'b0 || a_if.in_rdy !== 1'b1 || a_if.count !== 3'd3) begin
            errors++;
            $display("FAIL flush_cycle val=%b in_rdy=%b count=%0d want 0 1 3",
                     a_if.out_val, a_if.in_rdy, a_if.count);
        end
        qa.delete();
        tick();
        drv_a(1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (a_if.count !== 3'd0 || a_if.out_val !== 1'b0) begin
            errors++;
            $display("FAIL flush_after count=%0d val=%b want 0 0", a_if.count, a_if.out_val);
        end
        tick();
        push_a(8'hAA);
        push_a(8'hAB);
        for (int i = 0; i < 2; i++) begin
            drv_a(1'b0, 8'h00, 1'b1, 1'b0);
            @(negedge clk);
            exp_d = qa.pop_front();
            checks++;
            if (a_if.out_val !== 1'b1 || a_if.out_data !== exp_d) begin
                errors++;
                $display("FAIL flush_pop[%0d] val=%b data=%h want 1 %h",
                         i, a_if.out_val, a_if.out_data, exp_d);
            end
            tick();
        end
        drv_a(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_fallthru();
        drv_b(1'b1, 8'h5C, 1'b1, 1'b0);
        qb.push_back(8'h5C);
        @(negedge clk);
        exp_d = qb.pop_front();
        checks++;
        if (b_if.out_val !== 1'b1 || b_if.out_data !== exp_d || b_if.count !== 3'd0) begin
            errors++;
            $display("FAIL ft_bypass val=%b data=%h count=%0d want 1 %h 0",
                     b_if.out_val, b_if.out_data, b_if.count, exp_d);
        end
        tick();
        drv_b(1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (b_if.count !== 3'd0 || b_if.out_val !== 1'b0) begin
            errors++;
            $display("FAIL ft_bypass_after count=%0d val=%b want 0 0", b_if.count, b_if.out_val);
        end
        tick();
        drv_b(1'b1, 8'h5C, 1'b0, 1'b0);
        qb.push_back(8'h5C);
        @(negedge clk);
        checks++;
        if (b_if.out_val !== 1'b1 || b_if.out_data !== qb[0]) begin
            errors++;
            $display("FAIL ft_stall val=%b data=%h want 1 %h", b_if.out_val, b_if.out_data, qb[0]);
        end
        tick();
        drv_b(1'b0, 8'h00, 1'b1, 1'b0);
        @(negedge clk);
        exp_d = qb.pop_front();
        checks++;
        if (b_if.count !== 3'd1 || b_if.out_val !== 1'b1 || b_if.out_data !== exp_d) begin
            errors++;
            $display("FAIL ft_stored count=%0d val=%b data=%h want 1 1 %h",
                     b_if.count, b_if.out_val, b_if.out_data, exp_d);
        end
        tick();
        drv_b(1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (b_if.count !== 3'd0) begin
            errors++;
            $display("FAIL ft_empty count=%0d want 0", b_if.count);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) push_a(8'h50 + 8'(i));
        drv_a(1'b0, 8'h00, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (a_if.count !== 3'd0 || a_if.in_rdy !== 1'b1 || a_if.out_val !== 1'b0) begin
            errors++;
            $display("FAIL rstmid count=%0d in_rdy=%b val=%b want 0 1 0",
                     a_if.count, a_if.in_rdy, a_if.out_val);
        end
        checks++;
        if (a_if.almost_empty !== 1'b1 || a_if.almost_full !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_flags ae=%b af=%b want 1 0", a_if.almost_empty, a_if.almost_full);
        end
        #1;
        rst_n = 1'b1;
        qa.delete();
        tick();
        drv_a(1'b1, 8'h66, 1'b0, 1'b0);
        qa.push_back(8'h66);
        @(negedge clk);
        checks++;
        if (a_if.out_val !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_latency val=%b want 0", a_if.out_val);
        end
        tick();
        drv_a(1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        exp_d = qa.pop_front();
        checks++;
        if (a_if.out_val !== 1'b1 || a_if.out_data !== exp_d || a_if.count !== 3'd1) begin
            errors++;
            $display("FAIL rstmid_first val=%b data=%h count=%0d want 1 %h 1",
                     a_if.out_val, a_if.out_data, a_if.count, exp_d);
        end
        drv_a(1'b0, 8'h00, 1'b1, 1'b0);
        tick();
        drv_a(1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (a_if.count !== 3'd0) begin
            errors++;
            $display("FAIL rstmid_drain count=%0d want 0", a_if.count);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_back_to_back();
        test_full_pop();
        test_flush();
        test_fallthru();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
